// File: rtl/special_move_sequencer_if.sv
// Control bundle between the special-move sequencer and the datapath.
// The sequencer is the master: it takes run/opcode and drives every enable and select.
interface special_move_sequencer_if #(
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH  = 16
);
  logic                    run;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    PC_select;
  logic                    MAR_enable;
  logic                    PC_increment_enable;
  logic                    read;
  logic                    MDR_enable;
  logic                    MDR_select;
  logic                    IR_enable;
  logic                    Gra;
  logic                    r_enable;
  logic                    r_select;
  logic                    HI_select;
  logic                    LO_select;
  logic                    HI_enable;
  logic                    LO_enable;
  logic                    done;
  logic                    illegal;
  logic [COUNT_WIDTH-1:0]  retired;

  modport master (
    input  run, opcode,
    output PC_select, MAR_enable, PC_increment_enable, read, MDR_enable, MDR_select,
           IR_enable, Gra, r_enable, r_select, HI_select, LO_select, HI_enable, LO_enable,
           done, illegal, retired
  );

  modport slave (
    output run, opcode,
    input  PC_select, MAR_enable, PC_increment_enable, read, MDR_enable, MDR_select,
           IR_enable, Gra, r_enable, r_select, HI_select, LO_select, HI_enable, LO_enable,
           done, illegal, retired
  );
endinterface

// File: rtl/special_move_sequencer.sv
// Control FSM for mfhi/mflo/mthi/mtlo: fetch in T0..T2 (with optional memory wait
// states in T1), then one opcode-qualified execute step in T3.
module special_move_sequencer #(
  parameter int unsigned          OPCODE_WIDTH = 5,
  parameter int unsigned          MEM_WAIT     = 0,
  parameter int unsigned          COUNT_WIDTH  = 16,
  parameter logic [OPCODE_WIDTH-1:0] OP_MFHI   = 5'b11001,
  parameter logic [OPCODE_WIDTH-1:0] OP_MFLO   = 5'b11010,
  parameter logic [OPCODE_WIDTH-1:0] OP_MTHI   = 5'b10111,
  parameter logic [OPCODE_WIDTH-1:0] OP_MTLO   = 5'b11000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  special_move_sequencer_if.master bus
);

  localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

  typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3} state_e;

  state_e                 state_q;
  logic [3:0]             wait_q;
  logic [COUNT_WIDTH-1:0] retired_q;

  // Fetch-phase controls are registered alongside the state they belong to.
  logic pc_select_q, mar_enable_q, pc_inc_q, read_q, mdr_enable_q, mdr_select_q, ir_enable_q;

  // Execute-phase controls; opcode is only valid from T3 so these cannot be registered.
  logic gra, r_enable, r_select, hi_select, lo_select, hi_enable, lo_enable, done, illegal;

  // Decode the execute step from the live opcode while in T3.
  always_comb begin
    gra       = 1'b0;
    r_enable  = 1'b0;
    r_select  = 1'b0;
    hi_select = 1'b0;
    lo_select = 1'b0;
    hi_enable = 1'b0;
    lo_enable = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    if (state_q == StT3) begin
      case (bus.opcode)
        OP_MFHI: begin
          gra       = 1'b1;
          hi_select = 1'b1;
          r_enable  = 1'b1;
          done      = 1'b1;
        end
        OP_MFLO: begin
          gra       = 1'b1;
          lo_select = 1'b1;
          r_enable  = 1'b1;
          done      = 1'b1;
        end
        OP_MTHI: begin
          gra       = 1'b1;
          r_select  = 1'b1;
          hi_enable = 1'b1;
          done      = 1'b1;
        end
        OP_MTLO: begin
          gra       = 1'b1;
          r_select  = 1'b1;
          lo_enable = 1'b1;
          done      = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  // Sequencer state, wait-state counter, registered fetch controls and retire count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wait_q       <= 4'd0;
      retired_q    <= '0;
      pc_select_q  <= 1'b0;
      mar_enable_q <= 1'b0;
      pc_inc_q     <= 1'b0;
      read_q       <= 1'b0;
      mdr_enable_q <= 1'b0;
      mdr_select_q <= 1'b0;
      ir_enable_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.run) begin
            state_q      <= StT0;
            pc_select_q  <= 1'b1;
            mar_enable_q <= 1'b1;
          end
        end
        StT0: begin
          state_q      <= StT1;
          pc_select_q  <= 1'b0;
          mar_enable_q <= 1'b0;
          pc_inc_q     <= 1'b1;
          read_q       <= 1'b1;
          mdr_enable_q <= 1'b1;
        end
        StT1: begin
          // PC advances only in the first T1 cycle, however long memory takes.
          pc_inc_q <= 1'b0;
          if (wait_q == WaitLast) begin
            state_q      <= StT2;
            wait_q       <= 4'd0;
            read_q       <= 1'b0;
            mdr_enable_q <= 1'b0;
            mdr_select_q <= 1'b1;
            ir_enable_q  <= 1'b1;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        StT2: begin
          state_q      <= StT3;
          mdr_select_q <= 1'b0;
          ir_enable_q  <= 1'b0;
        end
        StT3: begin
          if (done) begin
            retired_q <= retired_q + COUNT_WIDTH'(1);
          end
          // Back-to-back issue goes straight to T0 with no idle bubble.
          if (bus.run) begin
            state_q      <= StT0;
            pc_select_q  <= 1'b1;
            mar_enable_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.PC_select           = pc_select_q;
  assign bus.MAR_enable          = mar_enable_q;
  assign bus.PC_increment_enable = pc_inc_q;
  assign bus.read                = read_q;
  assign bus.MDR_enable          = mdr_enable_q;
  assign bus.MDR_select          = mdr_select_q;
  assign bus.IR_enable           = ir_enable_q;
  assign bus.Gra                 = gra;
  assign bus.r_enable            = r_enable;
  assign bus.r_select            = r_select;
  assign bus.HI_select           = hi_select;
  assign bus.LO_select           = lo_select;
  assign bus.HI_enable           = hi_enable;
  assign bus.LO_enable           = lo_enable;
  assign bus.done                = done;
  assign bus.illegal             = illegal;
  assign bus.retired             = retired_q;

endmodule

// File: tb/tb_special_move_sequencer.sv
// Bench for special_move_sequencer: two instances (MEM_WAIT=0 with a 4-bit counter,
// MEM_WAIT=3 with a 16-bit counter). Each issued instruction pushes its per-cycle
// expected control vector onto a scoreboard queue that is popped once per cycle.
module tb_special_move_sequencer;

  localparam logic [4:0] OpMfhi = 5'b11001;
  localparam logic [4:0] OpMflo = 5'b11010;
  localparam logic [4:0] OpMthi = 5'b10111;
  localparam logic [4:0] OpMtlo = 5'b11000;
  localparam logic [4:0] OpBad  = 5'b00000;
  localparam logic [4:0] OpJunk = 5'b01010;

  localparam logic [15:0] VPcSel  = 16'h8000;
  localparam logic [15:0] VMar    = 16'h4000;
  localparam logic [15:0] VPcInc  = 16'h2000;
  localparam logic [15:0] VRead   = 16'h1000;
  localparam logic [15:0] VMdrEn  = 16'h0800;
  localparam logic [15:0] VMdrSel = 16'h0400;
  localparam logic [15:0] VIrEn   = 16'h0200;
  localparam logic [15:0] VGra    = 16'h0100;
  localparam logic [15:0] VREn    = 16'h0080;
  localparam logic [15:0] VRSel   = 16'h0040;
  localparam logic [15:0] VHiSel  = 16'h0020;
  localparam logic [15:0] VLoSel  = 16'h0010;
  localparam logic [15:0] VHiEn   = 16'h0008;
  localparam logic [15:0] VLoEn   = 16'h0004;
  localparam logic [15:0] VDone   = 16'h0002;
  localparam logic [15:0] VIll    = 16'h0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst3_n;

  special_move_sequencer_if #(.OPCODE_WIDTH(5), .COUNT_WIDTH(4))  bus0 ();
  special_move_sequencer_if #(.OPCODE_WIDTH(5), .COUNT_WIDTH(16)) bus3 ();

  special_move_sequencer #(.OPCODE_WIDTH(5), .MEM_WAIT(0), .COUNT_WIDTH(4)) dut0 (
    .clk     (clk),
    .reset_n (rst0_n),
    .bus     (bus0)
  );

  special_move_sequencer #(.OPCODE_WIDTH(5), .MEM_WAIT(3), .COUNT_WIDTH(16)) dut3 (
    .clk     (clk),
    .reset_n (rst3_n),
    .bus     (bus3)
  );

  typedef struct {
    string       tag;
    logic [15:0] vec;
    logic        run_after;
    logic [4:0]  op_after;
  } step_t;

  step_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int cnt0       = 0;
  int cnt3       = 0;

  function automatic logic [15:0] obs(input int d);
    if (d == 0) begin
      return {bus0.PC_select, bus0.MAR_enable, bus0.PC_increment_enable, bus0.read,
              bus0.MDR_enable, bus0.MDR_select, bus0.IR_enable, bus0.Gra, bus0.r_enable,
              bus0.r_select, bus0.HI_select, bus0.LO_select, bus0.HI_enable, bus0.LO_enable,
              bus0.done, bus0.illegal};
    end
    return {bus3.PC_select, bus3.MAR_enable, bus3.PC_increment_enable, bus3.read,
            bus3.MDR_enable, bus3.MDR_select, bus3.IR_enable, bus3.Gra, bus3.r_enable,
            bus3.r_select, bus3.HI_select, bus3.LO_select, bus3.HI_enable, bus3.LO_enable,
            bus3.done, bus3.illegal};
  endfunction

  function automatic logic [15:0] t3_vec(input logic [4:0] op);
    case (op)
      OpMfhi:  return VGra | VHiSel | VREn | VDone;
      OpMflo:  return VGra | VLoSel | VREn | VDone;
      OpMthi:  return VGra | VRSel | VHiEn | VDone;
      OpMtlo:  return VGra | VRSel | VLoEn | VDone;
      default: return VIll;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic [4:0] op);
    if (d == 0) begin
      bus0.run    = r;
      bus0.opcode = op;
    end else begin
      bus3.run    = r;
      bus3.opcode = op;
    end
  endtask

  task automatic push(input string tag, input logic [15:0] v, input logic r,
                      input logic [4:0] op);
    step_t s;
    s.tag       = tag;
    s.vec       = v;
    s.run_after = r;
    s.op_after  = op;
    sb.push_back(s);
  endtask

  // run is dropped during fetch to show it is ignored there; it is re-raised in T3 only
  // when another instruction follows.
  task automatic issue(input int mw, input logic [4:0] op, input logic more);
    push("t0", VPcSel | VMar, 1'b0, OpJunk);
    for (int i = 0; i <= mw; i++) begin
      push((i == 0) ? "t1_first" : "t1_wait", VRead | VMdrEn | ((i == 0) ? VPcInc : 16'h0),
           1'b0, OpJunk);
    end
    push("t2", VMdrSel | VIrEn, 1'b0, op);
    push("t3", t3_vec(op), more, op);
  endtask

  task automatic drain(input int d);
    step_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk);
      @(negedge clk);
      check(s.tag, 32'(obs(d)), 32'(s.vec));
      drive(d, s.run_after, s.op_after);
    end
  endtask

  initial begin
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    drive(0, 1'b0, OpBad);
    drive(3, 1'b0, OpBad);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_vec0", 32'(obs(0)), 32'h0);
    check("reset_vec3", 32'(obs(3)), 32'h0);
    check("reset_ret0", 32'(bus0.retired), 32'h0);
    check("reset_ret3", 32'(bus3.retired), 32'h0);
    rst0_n = 1'b1;
    rst3_n = 1'b1;

    // Idle with run low stays idle.
    for (int i = 0; i < 5; i++) push("idle", 16'h0, 1'b0, OpBad);
    drain(0);
    check("idle_ret0", 32'(bus0.retired), 32'h0);

    // Single mfhi, no wait states.
    drive(0, 1'b1, OpJunk);
    issue(0, OpMfhi, 1'b0);
    push("mfhi_idle", 16'h0, 1'b0, OpJunk);
    drain(0);
    cnt0++;
    check("mfhi_ret", 32'(bus0.retired), 32'(cnt0 % 16));

    // mflo with three wait states.
    drive(3, 1'b1, OpJunk);
    issue(3, OpMflo, 1'b0);
    push("mflo_idle", 16'h0, 1'b0, OpJunk);
    drain(3);
    cnt3++;
    check("mflo_ret", 32'(bus3.retired), 32'(cnt3));

    // Back-to-back mthi then mtlo.
    drive(0, 1'b1, OpJunk);
    issue(0, OpMthi, 1'b1);
    issue(0, OpMtlo, 1'b0);
    push("b2b_idle", 16'h0, 1'b0, OpJunk);
    drain(0);
    cnt0 += 2;
    check("b2b_ret", 32'(bus0.retired), 32'(cnt0 % 16));

    // Illegal opcode leaves the counter alone.
    drive(0, 1'b1, OpJunk);
    issue(0, OpBad, 1'b0);
    push("ill_idle", 16'h0, 1'b0, OpJunk);
    drain(0);
    check("ill_ret", 32'(bus0.retired), 32'(cnt0 % 16));

    // Reset in the second T1 cycle, with run high to show reset has priority.
    drive(3, 1'b1, OpJunk);
    push("mr_t0", VPcSel | VMar, 1'b0, OpJunk);
    push("mr_t1a", VRead | VMdrEn | VPcInc, 1'b0, OpJunk);
    push("mr_t1b", VRead | VMdrEn, 1'b1, OpJunk);
    drain(3);
    rst3_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cnt3 = 0;
    check("mr_vec", 32'(obs(3)), 32'h0);
    check("mr_ret", 32'(bus3.retired), 32'(cnt3));
    rst3_n = 1'b1;
    issue(3, OpMtlo, 1'b0);
    push("mr_idle", 16'h0, 1'b0, OpJunk);
    drain(3);
    cnt3++;
    check("mr_after_ret", 32'(bus3.retired), 32'(cnt3));

    // Counter wrap on the 4-bit instance: 17 legal instructions back-to-back.
    rst0_n = 1'b0;
    drive(0, 1'b0, OpJunk);
    @(posedge clk);
    @(negedge clk);
    rst0_n = 1'b1;
    cnt0 = 0;
    check("wrap_reset_ret", 32'(bus0.retired), 32'(cnt0));
    drive(0, 1'b1, OpJunk);
    for (int i = 0; i < 17; i++) begin
      case (i % 4)
        0:       issue(0, OpMfhi, (i < 16) ? 1'b1 : 1'b0);
        1:       issue(0, OpMflo, (i < 16) ? 1'b1 : 1'b0);
        2:       issue(0, OpMthi, (i < 16) ? 1'b1 : 1'b0);
        default: issue(0, OpMtlo, (i < 16) ? 1'b1 : 1'b0);
      endcase
    end
    push("wrap_idle", 16'h0, 1'b0, OpJunk);
    drain(0);
    cnt0 += 17;
    check("wrap_ret", 32'(bus0.retired), 32'(cnt0 % 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/special_move_sequencer.md
# special_move_sequencer

Parametrised control sequencer for the special-register move instructions (mfhi, mflo, mthi, mtlo). It replaces hand-timed control-signal stimulus with a hardware FSM that runs the three-step fetch (T0–T2) and one execute step (T3). It drives the datapath enables and selects directly. Beyond the single mfhi path, it adds:
- configurable memory wait states
- LO-side and move-to variants
- back-to-back issue
- illegal-opcode flagging
- a retired-instruction counter

## Interface
Parameters:
- OPCODE_WIDTH, 5, width of opcode input (IR[31:27])
- MEM_WAIT, 0, extra cycles `read`/`MDR_enable` are held in T1 (0..15)
- COUNT_WIDTH, 16, width of retired-instruction counter
- OP_MFHI, 5'b11001, opcode for mfhi
- OP_MFLO, 5'b11010, opcode for mflo
- OP_MTHI, 5'b10111, opcode for mthi
- OP_MTLO, 5'b11000, opcode for mtlo

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- run  in  1  start/continue request, sampled in IDLE and at end of T3
- opcode  in  OPCODE_WIDTH  opcode field of IR_Data, valid from T3 onward
- PC_select, MAR_enable  out  1  T0 controls
- PC_increment_enable, read, MDR_enable  out  1  T1 controls
- MDR_select, IR_enable  out  1  T2 controls
- Gra  out  1  select Ra field for register file
- r_enable  out  1  register-file write enable (mfhi/mflo)
- r_select  out  1  register-file drive onto bus (mthi/mtlo)
- HI_select, LO_select  out  1  HI/LO drive onto bus
- HI_enable, LO_enable  out  1  HI/LO load enables
- done  out  1  one-cycle pulse in the T3 cycle of a legal instruction
- illegal  out  1  one-cycle pulse in T3 when the opcode matches none of the four
- retired  out  COUNT_WIDTH  count of legal instructions completed

## Operation
- States: IDLE, T0, T1, T2, T3. State and wait counter are registered.
- Outputs are decoded from the state. T3 outputs are additionally qualified by `opcode`.
- IDLE:
  - All outputs 0.
  - run=1 → T0.
- T0: PC_select=1, MAR_enable=1 → T1.
- T1:
  - read=1 and MDR_enable=1 for MEM_WAIT+1 cycles.
  - PC_increment_enable=1 in the first T1 cycle only, so the PC advances exactly once.
  - When the wait counter reaches MEM_WAIT → T2.
- T2: MDR_select=1, IR_enable=1 → T3.
- T3, by opcode:
  - OP_MFHI: Gra, HI_select, r_enable.
  - OP_MFLO: Gra, LO_select, r_enable.
  - OP_MTHI: Gra, r_select, HI_enable.
  - OP_MTLO: Gra, r_select, LO_enable.
  - Any other opcode: only `illegal`=1; no enable or select asserted.
- Leaving T3:
  - run=1 → T0 (back-to-back issue, no IDLE bubble).
  - run=0 → IDLE.
- retired:
  - Increments by 1 at the T3 edge of each legal instruction.
  - Wraps modulo 2^COUNT_WIDTH.
  - Illegal opcodes do not increment it.
- At most one bus driver (PC_select, MDR_select, HI_select, LO_select, r_select) is high in any cycle.
- At most one of r_enable, HI_enable, LO_enable is high in any cycle.

## Timing
- Reset:
  - reset_n=0 at a rising edge → state IDLE, wait counter 0, retired 0.
  - All outputs read 0 after that edge.
  - This applies from any state, including mid-T1 wait.
  - reset_n takes priority over run.
- Latency from the edge where run is sampled high in IDLE to the T3 edge: 4+MEM_WAIT cycles.
- Instruction period under back-to-back issue: 4+MEM_WAIT cycles.
- `opcode` must be stable during T3. The sequencer does not latch it.
- done, illegal, and the retired update coincide with the T3 cycle.
- run changes during T0–T2 are ignored. run is sampled only in IDLE and T3.
- MEM_WAIT=0: T1 lasts exactly one cycle, and the wait counter never leaves 0.

## Test plan
- Reset/idle: hold reset_n=0 for 2 cycles, then run=0 for 5 cycles → every output 0, retired=0, state stays IDLE.
- Single mfhi, MEM_WAIT=0: pulse run=1 for one cycle, opcode=5'b11001 → T0..T3 in 4 cycles. In T3, Gra=r_enable=HI_select=done=1. PC_increment_enable high for exactly 1 cycle. retired=1. Returns to IDLE.
- Wait states, MEM_WAIT=3, mflo: read and MDR_enable high for 4 consecutive cycles. PC_increment_enable high only in the first of them. In T3, LO_select and r_enable are high. Total latency 7 cycles.
- Back-to-back: run held at 1, opcodes mthi then mtlo (MEM_WAIT=0) → second T0 directly follows the first T3. HI_enable then LO_enable, each 1 cycle. retired=2 after 8 cycles.
- Illegal opcode 5'b00000 → illegal=1 for 1 cycle in T3. done=0, every enable 0, retired unchanged.
- Reset mid-operation, MEM_WAIT=3: assert reset_n=0 on the 2nd T1 cycle → outputs 0 on the next edge and state IDLE. A later run starts a clean T0, and retired has been reset to 0.
- Counter wrap, COUNT_WIDTH=4: issue 17 legal instructions → retired reads 1.
